// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin sharing of one SPI controller
// among NREQ requesters, with per-transaction timeout abort.
module spi_txn_arbiter #(
  parameter int DATA    = 32,
  parameter int ADDR    = 3,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                 CLK,
  input  logic                 PRESETn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [NREQ*ADDR-1:0] req_addr,
  input  logic [NREQ*DATA-1:0] req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [DATA-1:0]      rdata,
  output logic                 busy,
  output logic                 spi_spe,
  output logic                 spi_mstr,
  output logic                 spi_ctrl,
  output logic [ADDR-1:0]      spi_addr,
  output logic [DATA-1:0]      spi_wdata,
  input  logic                 spi_sptef,
  input  logic                 spi_txc,
  input  logic [DATA-1:0]      spi_rdata
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]      st_q, st_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            wr_q, wr_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [DATA-1:0] wdata_q, wdata_d;
  logic [DATA-1:0] rdata_q, rdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic            found;
  logic [PW-1:0]   sel;
  logic [PW:0]     cand;
  logic [ADDR-1:0] addr_sel;
  logic [DATA-1:0] wdata_sel;
  logic            tmo;
  logic            act;

  // First pending requester after the last one served, with wrap.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(NREQ))
        cand = cand - (PW+1)'(NREQ);
      if (!found && req[cand[PW-1:0]]) begin
        found = 1'b1;
        sel   = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (sel == PW'(k)) begin
        addr_sel  = req_addr[k*ADDR +: ADDR];
        wdata_sel = req_wdata[k*DATA +: DATA];
      end
    end
  end

  assign tmo = (cnt_q == CW'(TIMEOUT-1));

  always_comb begin
    st_d    = st_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (st_q)
      S_IDLE: begin
        err_d = 1'b0;
        if (found) begin
          wr_d    = req_wr[sel];
          addr_d  = addr_sel;
          wdata_d = wdata_sel;
          gidx_d  = sel;
          gnt_d   = NREQ'(1) << sel;
          cnt_d   = '0;
          st_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d = cnt_q + 1'b1;
        if (!wr_q || spi_sptef) begin
          st_d = S_XFER;
        end else if (tmo) begin
          st_d  = S_DONE;
          err_d = 1'b1;
        end
      end
      S_XFER: begin
        cnt_d = cnt_q + 1'b1;
        // A completing transfer beats a simultaneous expiry.
        if (spi_txc) begin
          if (!wr_q)
            rdata_d = spi_rdata;
          st_d = S_DONE;
        end else if (tmo) begin
          st_d  = S_DONE;
          err_d = 1'b1;
        end
      end
      S_DONE: begin
        ptr_d = gidx_q;
        gnt_d = '0;
        st_d  = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge PRESETn) begin
    if (!PRESETn) begin
      st_q    <= S_IDLE;
      ptr_q   <= PW'(NREQ-1);
      gidx_q  <= '0;
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign act       = (st_q == S_SETUP) || (st_q == S_XFER);
  assign busy      = (st_q != S_IDLE);
  assign gnt       = gnt_q;
  assign done      = (st_q == S_DONE) ? gnt_q : '0;
  assign err       = (st_q == S_DONE) && err_q;
  assign rdata     = rdata_q;
  assign spi_spe   = act;
  assign spi_mstr  = act && wr_q;
  assign spi_ctrl  = act && wr_q;
  assign spi_addr  = act ? addr_q : '0;
  assign spi_wdata = act ? wdata_q : '0;

endmodule
